br_predictor: RTL and testbench
===============================

BR_PREDICTOR -- requirements
Module: br_predictor

Interface
REQ-001 SHALL have parameter BTB_IDX_W, default 6, giving 2^BTB_IDX_W direct-mapped BTB entries.
REQ-002 SHALL have parameter RAS_DEPTH, default 8, giving the return-address-stack entry count (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port IF_pc  input  32  fetch-group PC; slot a = IF_pc, slot b = IF_pc+4.
REQ-006 SHALL have port IF_stall  input  1  hold prediction outputs.
REQ-007 SHALL have port EX_pc_of_br  input  32  PC of resolved branch.
REQ-008 SHALL have port EX_pd_type  input  2  resolved type: 00 none, 01 conditional, 10 call, 11 return; 00 means no update.
REQ-009 SHALL have port EX_br_target  input  32  resolved taken-target.
REQ-010 SHALL have port EX_br_jump  input  1  resolved taken flag.
REQ-011 SHALL have ports IF_br_pd_a, IF_br_pd_b  output  1  predicted-taken per slot.
REQ-012 SHALL have ports IF_pc_pd_a, IF_pc_pd_b  output  32  predicted next PC per slot.
REQ-013 SHALL have ports IF_pd_type_a, IF_pd_type_b  output  2  predicted type per slot (00 on miss).

Function
REQ-014 SHALL split a PC into index PC[BTB_IDX_W+1:2] and tag PC[31:BTB_IDX_W+2].
REQ-015 SHALL hold per BTB entry: valid, tag, target[31:2], type[1:0], 2-bit saturating counter.
REQ-016 SHALL treat a slot as a hit when the indexed entry is valid and its tag matches.
REQ-017 SHALL predict taken on a hit when type is 10 or 11, or when type is 01 and counter[1]=1.
REQ-018 SHALL set the taken target to the RAS top for type 11 with RAS non-empty; otherwise it SHALL be {entry target,2'b00}.
REQ-019 SHALL set a not-taken slot's IF_pc_pd to its own PC+4 and IF_br_pd to 0.
REQ-020 SHALL, when slot a is predicted taken, force IF_br_pd_b=0, IF_pd_type_b=00 and IF_pc_pd_b=IF_pc+8.
REQ-021 SHALL register the outputs with latency 1 (IF_pc at edge N, outputs valid after edge N+1) and hold them unchanged while IF_stall=1.
REQ-022 SHALL, on EX_pd_type!=00, write the entry at the EX_pc_of_br index: valid=1, tag, target, type=EX_pd_type.
REQ-023 SHALL load the counter on a miss/replace as EX_br_jump?2'b10:2'b01; on a tag hit it SHALL increment if jump and decrement otherwise, saturating at 11 and 00.
REQ-024 SHALL push EX_pc_of_br+4 on the RAS when EX_pd_type=10.
REQ-025 SHALL pop the RAS when EX_pd_type=11.
REQ-026 SHALL make the RAS circular: a push when full overwrites the oldest entry (count saturates at RAS_DEPTH); a pop when empty is a no-op.
REQ-027 SHALL make a same-cycle lookup and update of one index return the pre-update contents; the update SHALL be visible to a lookup issued the following cycle.
REQ-028 SHALL make RAS pushes/pops from EX affect only lookups issued after the update edge.
REQ-029 SHALL update BTB and RAS regardless of IF_stall.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear all valid bits, set all counters to 01 and empty the RAS.
REQ-031 SHALL drive all outputs to 0 while rst=1, including IF_pc_pd_*.
REQ-032 SHALL make rst override a simultaneous update, discarding that update.

Verification
REQ-033 SHALL cover: after reset, IF_pc=0x1C000000 -> IF_br_pd_a=0, IF_pc_pd_a=0x1C000004, IF_pc_pd_b=0x1C000008.
REQ-034 SHALL cover: update pc=0x1C000010, type 01, jump=1, target 0x1C000100, then lookup IF_pc=0x1C000010 -> br_pd_a=1, pc_pd_a=0x1C000100, br_pd_b=0, pc_pd_b=0x1C000018.
REQ-035 SHALL cover: from REQ-034, two updates with jump=0 -> counter 10->01->00, lookup predicts not-taken with pc_pd_a=0x1C000014.
REQ-036 SHALL cover: call update at 0x1C000020, then return entry at 0x1C000104 -> lookup predicts target 0x1C000024; a return update pops, and the next lookup with RAS empty uses the BTB target.
REQ-037 SHALL cover: 9 calls with RAS_DEPTH=8, then 9 returns -> first 8 pops yield PCs of calls 9..2, ninth pop is a no-op.
REQ-038 SHALL cover: aliasing pc 0x1C000010 vs 0x1C001010 (same index) -> tag miss with no prediction, replacement resets the counter per REQ-023; with IF_stall=1 the outputs stay frozen across the update.

Source files
------------

// File: rtl/br_predictor.sv
// Two-slot fetch branch predictor: direct-mapped BTB with 2-bit counters plus a
// circular return-address stack, lookups registered with one cycle of latency.
module br_predictor #(
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_pc,
  input  logic        IF_stall,
  input  logic [31:0] EX_pc_of_br,
  input  logic [1:0]  EX_pd_type,
  input  logic [31:0] EX_br_target,
  input  logic        EX_br_jump,
  output logic        IF_br_pd_a,
  output logic        IF_br_pd_b,
  output logic [31:0] IF_pc_pd_a,
  output logic [31:0] IF_pc_pd_b,
  output logic [1:0]  IF_pd_type_a,
  output logic [1:0]  IF_pd_type_b
);

  localparam int unsigned ENTRIES = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W   = 30 - BTB_IDX_W;
  localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W   = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_COND = 2'b01;
  localparam logic [1:0] T_CALL = 2'b10;
  localparam logic [1:0] T_RET  = 2'b11;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [29:0]      tgt_q   [ENTRIES];
  logic [1:0]       type_q  [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [31:0]      ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic [31:0]      ras_top;

  logic                 upd_en;
  logic                 upd_hit;
  logic [BTB_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic [1:0]           ctr_d;

  logic unused_tgt_lo;
  assign unused_tgt_lo = ^EX_br_target[1:0];

  // ---------------- BTB update ----------------
  assign upd_en  = (EX_pd_type != T_NONE);
  assign upd_idx = EX_pc_of_br[BTB_IDX_W+1:2];
  assign upd_tag = EX_pc_of_br[31:BTB_IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // A replaced entry restarts weakly biased toward the resolved direction
  always_comb begin
    ctr_d = ctr_q[upd_idx];
    if (!upd_hit) begin
      ctr_d = EX_br_jump ? 2'b10 : 2'b01;
    end else if (EX_br_jump && (ctr_q[upd_idx] != 2'b11)) begin
      ctr_d = ctr_q[upd_idx] + 2'b01;
    end else if (!EX_br_jump && (ctr_q[upd_idx] != 2'b00)) begin
      ctr_d = ctr_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_en) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && upd_en) begin
      tag_q[upd_idx]  <= upd_tag;
      tgt_q[upd_idx]  <= EX_br_target[31:2];
      type_q[upd_idx] <= EX_pd_type;
    end
  end

  // ---------------- return-address stack ----------------
  // Pointer wraps freely, so a push when full overwrites the oldest entry
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (EX_pd_type == T_CALL) begin
      ras_ptr_d = ras_ptr_q + PTR_W'(1);
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
        ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end
    end else if ((EX_pd_type == T_RET) && (ras_cnt_q != '0)) begin
      ras_ptr_d = ras_ptr_q - PTR_W'(1);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (EX_pd_type == T_CALL)) begin
      ras_q[ras_ptr_q] <= EX_pc_of_br + 32'd4;
    end
  end

  assign ras_top = ras_q[ras_ptr_q - PTR_W'(1)];

  // ---------------- lookup ----------------
  logic [31:0]          slot_pc  [2];
  logic [31:0]          slot_nxt [2];
  logic [BTB_IDX_W-1:0] slot_idx [2];
  logic                 slot_hit [2];
  logic                 slot_tk  [2];
  logic [1:0]           slot_ty  [2];

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      slot_pc[s]  = IF_pc + 32'(4 * s);
      slot_idx[s] = slot_pc[s][BTB_IDX_W+1:2];
      slot_hit[s] = valid_q[slot_idx[s]] &&
                    (tag_q[slot_idx[s]] == slot_pc[s][31:BTB_IDX_W+2]);
      slot_ty[s]  = slot_hit[s] ? type_q[slot_idx[s]] : T_NONE;
      slot_tk[s]  = (slot_ty[s] == T_CALL) || (slot_ty[s] == T_RET) ||
                    ((slot_ty[s] == T_COND) && ctr_q[slot_idx[s]][1]);
      if (!slot_tk[s]) begin
        slot_nxt[s] = slot_pc[s] + 32'd4;
      end else if ((slot_ty[s] == T_RET) && (ras_cnt_q != '0)) begin
        slot_nxt[s] = ras_top;
      end else begin
        slot_nxt[s] = {tgt_q[slot_idx[s]], 2'b00};
      end
    end
  end

  // ---------------- registered outputs ----------------
  logic        br_a_q, br_a_d, br_b_q, br_b_d;
  logic [31:0] pc_a_q, pc_a_d, pc_b_q, pc_b_d;
  logic [1:0]  ty_a_q, ty_a_d, ty_b_q, ty_b_d;

  // A taken slot a redirects fetch, so slot b is squashed
  always_comb begin
    br_a_d = slot_tk[0];
    pc_a_d = slot_nxt[0];
    ty_a_d = slot_ty[0];
    br_b_d = slot_tk[1];
    pc_b_d = slot_nxt[1];
    ty_b_d = slot_ty[1];
    if (slot_tk[0]) begin
      br_b_d = 1'b0;
      ty_b_d = T_NONE;
      pc_b_d = IF_pc + 32'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_a_q <= 1'b0;
      br_b_q <= 1'b0;
      pc_a_q <= '0;
      pc_b_q <= '0;
      ty_a_q <= T_NONE;
      ty_b_q <= T_NONE;
    end else if (!IF_stall) begin
      br_a_q <= br_a_d;
      br_b_q <= br_b_d;
      pc_a_q <= pc_a_d;
      pc_b_q <= pc_b_d;
      ty_a_q <= ty_a_d;
      ty_b_q <= ty_b_d;
    end
  end

  assign IF_br_pd_a   = br_a_q;
  assign IF_br_pd_b   = br_b_q;
  assign IF_pc_pd_a   = pc_a_q;
  assign IF_pc_pd_b   = pc_b_q;
  assign IF_pd_type_a = ty_a_q;
  assign IF_pd_type_b = ty_b_q;

endmodule

// File: tb/tb_br_predictor.sv
// Bench for br_predictor: hand-derived vector table, directed RAS/reset
// sequences and a randomized run against an array/queue reference model.
module tb_br_predictor;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NENT  = 1 << IDX_W;

  logic        clk;
  logic        rst;
  logic [31:0] IF_pc;
  logic        IF_stall;
  logic [31:0] EX_pc_of_br;
  logic [1:0]  EX_pd_type;
  logic [31:0] EX_br_target;
  logic        EX_br_jump;
  logic        IF_br_pd_a, IF_br_pd_b;
  logic [31:0] IF_pc_pd_a, IF_pc_pd_b;
  logic [1:0]  IF_pd_type_a, IF_pd_type_b;

  br_predictor #(.BTB_IDX_W(IDX_W), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .IF_pc(IF_pc), .IF_stall(IF_stall),
    .EX_pc_of_br(EX_pc_of_br), .EX_pd_type(EX_pd_type),
    .EX_br_target(EX_br_target), .EX_br_jump(EX_br_jump),
    .IF_br_pd_a(IF_br_pd_a), .IF_br_pd_b(IF_br_pd_b),
    .IF_pc_pd_a(IF_pc_pd_a), .IF_pc_pd_b(IF_pc_pd_b),
    .IF_pd_type_a(IF_pd_type_a), .IF_pd_type_b(IF_pd_type_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        br_a;
    logic [31:0] pc_a;
    logic [1:0]  ty_a;
    logic        br_b;
    logic [31:0] pc_b;
    logic [1:0]  ty_b;
  } out_t;

  typedef struct {
    logic        stall;
    logic [31:0] pc;
    logic [1:0]  et;
    logic [31:0] epc;
    logic [31:0] etgt;
    logic        ej;
    out_t        exp;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  bit          m_valid [NENT];
  logic [31:0] m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_type  [NENT];
  int          m_ctr   [NENT];
  logic [31:0] m_ras   [$];
  out_t        m_out;

  function automatic out_t o(input logic ba, input logic [31:0] pa, input logic [1:0] ta,
                             input logic bb, input logic [31:0] pb, input logic [1:0] tb);
    out_t r;
    r.br_a = ba; r.pc_a = pa; r.ty_a = ta;
    r.br_b = bb; r.pc_b = pb; r.ty_b = tb;
    return r;
  endfunction

  function automatic vec_t v(input logic st, input logic [31:0] pc, input logic [1:0] et,
                             input logic [31:0] epc, input logic [31:0] etgt,
                             input logic ej, input out_t e);
    vec_t r;
    r.stall = st; r.pc = pc; r.et = et; r.epc = epc; r.etgt = etgt; r.ej = ej; r.exp = e;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_ras.delete();
  endtask

  function automatic out_t predict(input logic [31:0] pc);
    out_t        r;
    logic [31:0] p;
    logic [31:0] nxt [2];
    bit          tk  [2];
    int          ty  [2];
    int          idx;
    for (int s = 0; s < 2; s++) begin
      p      = pc + 32'(4 * s);
      idx    = int'((p / 4) % NENT);
      ty[s]  = 0;
      tk[s]  = 1'b0;
      nxt[s] = p + 32'd4;
      if (m_valid[idx] && (m_tag[idx] == p / (4 * NENT))) begin
        ty[s] = m_type[idx];
        tk[s] = (ty[s] >= 2) || (ty[s] == 1 && m_ctr[idx] >= 2);
        if (tk[s]) nxt[s] = (ty[s] == 3 && m_ras.size() > 0) ? m_ras[$] : m_tgt[idx];
      end
    end
    if (tk[0]) begin
      tk[1]  = 1'b0;
      ty[1]  = 0;
      nxt[1] = pc + 32'd8;
    end
    r = o(tk[0], nxt[0], 2'(ty[0]), tk[1], nxt[1], 2'(ty[1]));
    return r;
  endfunction

  task automatic model_update(input logic [1:0] et, input logic [31:0] epc,
                              input logic [31:0] etgt, input logic ej);
    int idx;
    bit hit;
    if (et == 2'b00) return;
    idx = int'((epc / 4) % NENT);
    hit = m_valid[idx] && (m_tag[idx] == epc / (4 * NENT));
    if (!hit)    m_ctr[idx] = ej ? 2 : 1;
    else if (ej) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
    else         m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = epc / (4 * NENT);
    m_tgt[idx]   = etgt & ~32'h3;
    m_type[idx]  = int'(et);
    if (et == 2'b10) begin
      m_ras.push_back(epc + 32'd4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (et == 2'b11 && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endtask

  task automatic check(input out_t want, input string name);
    out_t got;
    got = o(IF_br_pd_a, IF_pc_pd_a, IF_pd_type_a, IF_br_pd_b, IF_pc_pd_b, IF_pd_type_b);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t: got br_a=%0b pc_a=%h ty_a=%0d br_b=%0b pc_b=%h ty_b=%0d | want br_a=%0b pc_a=%h ty_a=%0d br_b=%0b pc_b=%h ty_b=%0d",
               name, $time, got.br_a, got.pc_a, got.ty_a, got.br_b, got.pc_b, got.ty_b,
               want.br_a, want.pc_a, want.ty_a, want.br_b, want.pc_b, want.ty_b);
    end
  endtask

  // One clock: drive at negedge, advance model across the edge, compare at next negedge
  task automatic cycle(input logic r, input logic st, input logic [31:0] pc,
                       input logic [1:0] et, input logic [31:0] epc,
                       input logic [31:0] etgt, input logic ej);
    rst = r; IF_stall = st; IF_pc = pc;
    EX_pd_type = et; EX_pc_of_br = epc; EX_br_target = etgt; EX_br_jump = ej;
    if (r)        m_out = '0;
    else if (!st) m_out = predict(pc);
    if (r) model_reset();
    else   model_update(et, epc, etgt, ej);
    @(posedge clk);
    @(negedge clk);
    check(m_out, "model");
  endtask

  vec_t        tbl [$];
  logic [31:0] want;

  initial begin
    // directed vectors; expectations are outputs after that row's clock edge
    tbl.push_back(v(0, 32'h1C000000, 2'b00, 0, 0, 0, o(0, 32'h1C000004, 0, 0, 32'h1C000008, 0)));
    tbl.push_back(v(0, 32'h1C000000, 2'b01, 32'h1C000010, 32'h1C000100, 1, o(0, 32'h1C000004, 0, 0, 32'h1C000008, 0)));
    tbl.push_back(v(0, 32'h1C000010, 2'b00, 0, 0, 0, o(1, 32'h1C000100, 1, 0, 32'h1C000018, 0)));
    tbl.push_back(v(0, 32'h1C000010, 2'b01, 32'h1C000010, 32'h1C000100, 0, o(1, 32'h1C000100, 1, 0, 32'h1C000018, 0)));
    tbl.push_back(v(0, 32'h1C000010, 2'b01, 32'h1C000010, 32'h1C000100, 0, o(0, 32'h1C000014, 1, 0, 32'h1C000018, 0)));
    tbl.push_back(v(0, 32'h1C000010, 2'b00, 0, 0, 0, o(0, 32'h1C000014, 1, 0, 32'h1C000018, 0)));
    tbl.push_back(v(0, 32'h1C000104, 2'b11, 32'h1C000104, 32'h1C000200, 1, o(0, 32'h1C000108, 0, 0, 32'h1C00010C, 0)));
    tbl.push_back(v(0, 32'h1C000104, 2'b10, 32'h1C000020, 32'h1C000100, 1, o(1, 32'h1C000200, 3, 0, 32'h1C00010C, 0)));
    tbl.push_back(v(0, 32'h1C000104, 2'b00, 0, 0, 0, o(1, 32'h1C000024, 3, 0, 32'h1C00010C, 0)));
    tbl.push_back(v(0, 32'h1C000104, 2'b11, 32'h1C000104, 32'h1C000200, 1, o(1, 32'h1C000024, 3, 0, 32'h1C00010C, 0)));
    tbl.push_back(v(0, 32'h1C000104, 2'b00, 0, 0, 0, o(1, 32'h1C000200, 3, 0, 32'h1C00010C, 0)));
    tbl.push_back(v(0, 32'h1C00001C, 2'b00, 0, 0, 0, o(0, 32'h1C000020, 0, 1, 32'h1C000100, 2)));
    tbl.push_back(v(0, 32'h1C001010, 2'b00, 0, 0, 0, o(0, 32'h1C001014, 0, 0, 32'h1C001018, 0)));
    tbl.push_back(v(0, 32'h1C001010, 2'b01, 32'h1C001010, 32'h1C002000, 0, o(0, 32'h1C001014, 0, 0, 32'h1C001018, 0)));
    tbl.push_back(v(0, 32'h1C001010, 2'b00, 0, 0, 0, o(0, 32'h1C001014, 1, 0, 32'h1C001018, 0)));
    tbl.push_back(v(0, 32'h1C001010, 2'b01, 32'h1C001010, 32'h1C002000, 1, o(0, 32'h1C001014, 1, 0, 32'h1C001018, 0)));
    tbl.push_back(v(0, 32'h1C001010, 2'b00, 0, 0, 0, o(1, 32'h1C002000, 1, 0, 32'h1C001018, 0)));
    tbl.push_back(v(0, 32'h1C000010, 2'b00, 0, 0, 0, o(0, 32'h1C000014, 0, 0, 32'h1C000018, 0)));
    tbl.push_back(v(1, 32'h1C001010, 2'b01, 32'h1C001010, 32'h1C002000, 0, o(0, 32'h1C000014, 0, 0, 32'h1C000018, 0)));
    tbl.push_back(v(1, 32'h1C000000, 2'b00, 0, 0, 0, o(0, 32'h1C000014, 0, 0, 32'h1C000018, 0)));
    tbl.push_back(v(0, 32'h1C001010, 2'b00, 0, 0, 0, o(0, 32'h1C001014, 1, 0, 32'h1C001018, 0)));

    cycle(1, 0, 32'h1C000000, 2'b00, 0, 0, 0);
    cycle(1, 0, 32'h1C000000, 2'b00, 0, 0, 0);
    check('0, "reset");

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(0, tbl[i].stall, tbl[i].pc, tbl[i].et, tbl[i].epc, tbl[i].etgt, tbl[i].ej);
      check(tbl[i].exp, $sformatf("vec%0d", i));
    end

    // reset wins over a simultaneous update
    cycle(1, 0, 32'h1C000010, 2'b01, 32'h1C000050, 32'h1C000500, 1);
    check('0, "rst_outputs");
    cycle(0, 0, 32'h1C000050, 2'b00, 0, 0, 0);
    check(o(0, 32'h1C000054, 0, 0, 32'h1C000058, 0), "rst_discard");

    // RAS overflow: 9 calls into an 8-deep stack, then 9 pops
    cycle(0, 0, 32'h1C000000, 2'b11, 32'h1C000104, 32'h1C000200, 1);
    for (int k = 1; k <= 9; k++)
      cycle(0, 0, 32'h1C000000, 2'b10, 32'h1C000400 + 32'(16 * k), 32'h1C000800, 1);
    for (int i = 1; i <= 9; i++) begin
      cycle(0, 0, 32'h1C000104, 2'b11, 32'h1C000104, 32'h1C000200, 1);
      want = (i <= 8) ? 32'h1C000400 + 32'(16 * (10 - i)) + 32'd4 : 32'h1C000200;
      check(o(1, want, 3, 0, 32'h1C00010C, 0), $sformatf("ras_pop%0d", i));
    end
    cycle(0, 0, 32'h1C000104, 2'b00, 0, 0, 0);
    check(o(1, 32'h1C000200, 3, 0, 32'h1C00010C, 0), "ras_empty");

    // randomized traffic over a few aliasing address regions
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] lpc, epc;
      lpc = 32'h1C000000 + 32'($urandom_range(0, 2) << 12) + 32'($urandom_range(0, 63) << 2);
      epc = 32'h1C000000 + 32'($urandom_range(0, 2) << 12) + 32'($urandom_range(0, 63) << 2);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0), lpc,
            2'($urandom_range(0, 3)), epc, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
